bp_me_cce_req_mux: RTL and testbench

BP_ME_CCE_REQ_MUX -- requirements
Module: bp_me_cce_req_mux

---
 rtl/bp_me_cce_req_mux.sv | 156 +++++++++++++++
 tb/tb_bp_me_cce_req_mux.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_cce_req_mux.sv
// Round-robin LCE-to-CCE request multiplexer with per-channel accept counters.
// Define BP_ME_CCE_REQ_MUX_WATCHDOG_EN to build in the stall watchdog.
module bp_me_cce_req_mux #(
  parameter int num_lce_p     = 4,
  parameter int msg_width_p   = 128,
  parameter int ctr_width_p   = 16,
  parameter int stall_limit_p = 1024
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_lce_p*msg_width_p-1:0] lce_req_i,
  input  logic [num_lce_p-1:0]             lce_req_v_i,
  output logic [num_lce_p-1:0]             lce_req_yumi_o,
  output logic [msg_width_p-1:0]           cce_req_o,
  output logic                             cce_req_v_o,
  input  logic                             cce_req_yumi_i,
  input  logic                             clear_i,
  output logic [num_lce_p*ctr_width_p-1:0] accept_count_o,
  output logic                             stall_o
);

  localparam int ptr_w = $clog2(num_lce_p);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                              state_q, state_d;
  logic [ptr_w-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [ptr_w-1:0]                    sel_q, sel_d;
  logic [ptr_w-1:0]                    winner;
  logic                                winner_v;
  logic [ptr_w-1:0]                    present;
  logic                                req_v;
  logic                                xfer;
  logic [num_lce_p-1:0][ctr_width_p-1:0] cnt_q;

  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
    return (int'(p) == num_lce_p - 1) ? '0 : p + 1'b1;
  endfunction

  // First valid channel at or above rr_ptr_q, wrapping past the top.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    winner   = '0;
    winner_v = 1'b0;
    for (int unsigned k = 0; k < num_lce_p; k++) begin
      idx = (int'(rr_ptr_q) + k) % num_lce_p;
      if (!winner_v && lce_req_v_i[idx]) begin
        winner_v = 1'b1;
        winner   = ptr_w'(idx);
      end
    end
  end

  assign present = (state_q == LOCKED) ? sel_q : winner;
  // Gated by reset so nothing is offered while the block is held in reset.
  assign req_v   = reset_n_i & ((state_q == LOCKED) | winner_v);
  assign xfer    = req_v & cce_req_yumi_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    case (state_q)
      IDLE: begin
        if (winner_v) begin
          if (cce_req_yumi_i) begin
            rr_ptr_d = next_ptr(winner);
          end else begin
            sel_d   = winner;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (cce_req_yumi_i) begin
          rr_ptr_d = next_ptr(sel_q);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cce_req_v_o    = req_v;
    cce_req_o      = '0;
    lce_req_yumi_o = '0;
    if (req_v) begin
      cce_req_o = lce_req_i[int'(present)*msg_width_p +: msg_width_p];
    end
    if (xfer) begin
      lce_req_yumi_o[present] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < num_lce_p; i++) begin
        if (clear_i) begin
          cnt_q[i] <= '0;
        end else if (xfer && (present == ptr_w'(i)) && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign accept_count_o = cnt_q;

`ifdef BP_ME_CCE_REQ_MUX_WATCHDOG_EN
  logic [19:0] stall_cnt_q, stall_cnt_d;
  logic        stall_q;

  // Counter saturates at the limit so a long stall cannot wrap it back under.
  always_comb begin
    stall_cnt_d = '0;
    if (req_v && !cce_req_yumi_i) begin
      stall_cnt_d = (stall_cnt_q == 20'(stall_limit_p)) ? stall_cnt_q : stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (clear_i) begin
        stall_q <= 1'b0;
      end else if (stall_cnt_d == 20'(stall_limit_p)) begin
        stall_q <= 1'b1;
      end
    end
  end

  assign stall_o = stall_q;
`else
  assign stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_me_cce_req_mux.sv
// Directed bench for bp_me_cce_req_mux: behavioural arbiter model checked every
// cycle plus literal expectations for the key arbitration/counter/reset cases.
module tb_bp_me_cce_req_mux;

  localparam int N  = 4;
  localparam int MW = 16;
  localparam int CW = 4;
  localparam int SL = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [MW-1:0]   dat [N];
  logic [N*MW-1:0] lce_req;
  logic [N-1:0]    lce_v = '0;
  logic [N-1:0]    yumi_o;
  logic [MW-1:0]   cce_req;
  logic            cce_v;
  logic            yumi = 1'b0;
  logic            clear = 1'b0;
  logic [N*CW-1:0] counts;
  logic            stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    lce_req = '0;
    for (int i = 0; i < N; i++) lce_req[i*MW +: MW] = dat[i];
  end

  bp_me_cce_req_mux #(
    .num_lce_p    (N),
    .msg_width_p  (MW),
    .ctr_width_p  (CW),
    .stall_limit_p(SL)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (rst_n),
    .lce_req_i     (lce_req),
    .lce_req_v_i   (lce_v),
    .lce_req_yumi_o(yumi_o),
    .cce_req_o     (cce_req),
    .cce_req_v_o   (cce_v),
    .cce_req_yumi_i(yumi),
    .clear_i       (clear),
    .accept_count_o(counts),
    .stall_o       (stall)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the channel being offered is the held one, else the first valid from the pointer.
  int m_lock = -1;
  int m_rr   = 0;
  int m_cnt [N];
  int m_scnt = 0;
  bit m_stall = 1'b0;

  function automatic int m_pick();
    if (m_lock >= 0) return m_lock;
    for (int k = 0; k < N; k++) if (lce_v[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int p;
    int ns;
    if (!rst_n) begin
      m_lock  <= -1;
      m_rr    <= 0;
      m_scnt  <= 0;
      m_stall <= 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] <= 0;
    end else begin
      p = m_pick();
      for (int i = 0; i < N; i++) begin
        if (clear) m_cnt[i] <= 0;
        else if (p == i && yumi) m_cnt[i] <= (m_cnt[i] + 1 > 15) ? 15 : m_cnt[i] + 1;
      end
      if (p >= 0 && yumi) begin
        m_lock <= -1;
        m_rr   <= (p + 1) % N;
      end else if (p >= 0) begin
        m_lock <= p;
      end
`ifdef BP_ME_CCE_REQ_MUX_WATCHDOG_EN
      ns = (p >= 0 && !yumi) ? ((m_scnt + 1 > SL) ? SL : m_scnt + 1) : 0;
      m_scnt <= ns;
      if (clear) m_stall <= 1'b0;
      else if (ns >= SL) m_stall <= 1'b1;
`else
      ns = 0;
      m_scnt <= ns;
`endif
    end
  end

  always @(negedge clk) begin
    int p;
    logic [N-1:0]  ey;
    logic [MW-1:0] ed;
    logic          ev;
    p  = m_pick();
    ev = rst_n && (p >= 0);
    ed = '0;
    ey = '0;
    if (ev) ed = dat[p];
    if (ev && yumi) ey[p] = 1'b1;
    chk("cmp_v", 128'(cce_v), 128'(ev));
    chk("cmp_data", 128'(cce_req), 128'(ed));
    chk("cmp_yumi", 128'(yumi_o), 128'(ey));
    for (int i = 0; i < N; i++) chk("cmp_count", 128'(counts[i*CW +: CW]), 128'(m_cnt[i]));
    chk("cmp_stall", 128'(stall), 128'(m_stall));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int order [5];
    bit exp_stall;
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) dat[i] = 16'hC000 + 16'(i * 'h111);

    #1 rst_n = 1'b0;
    #1;
    chk("reset_v", 128'(cce_v), 128'(0));
    chk("reset_count", 128'(counts), 128'(0));
    chk("reset_stall", 128'(stall), 128'(0));
    step();
    step();
    rst_n = 1'b1;

    // All valid, consumed every cycle: strict rotation.
    lce_v = 4'hF;
    yumi  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rot_yumi", 128'(yumi_o), 128'(4'b0001 << order[c]));
      step();
    end
    lce_v = '0;
    yumi  = 1'b0;
    @(negedge clk);
    chk("rot_counts", 128'(counts), 128'({4'd1, 4'd1, 4'd1, 4'd2}));
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    chk("clear_counts", 128'(counts), 128'(0));

    // Channel 2 held under back-pressure; a later channel 0 request waits.
    step();
    lce_v = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("lock_data", 128'(cce_req), 128'(dat[2]));
      step();
    end
    lce_v = 4'b0101;
    @(negedge clk);
    chk("lock_hold", 128'(cce_req), 128'(dat[2]));
    step();
    yumi = 1'b1;
    @(negedge clk);
    chk("lock_yumi", 128'(yumi_o), 128'(4'b0100));
    step();
    lce_v = 4'b0001;
    @(negedge clk);
    chk("skip3_yumi", 128'(yumi_o), 128'(4'b0001));
    step();
    lce_v = '0;
    yumi  = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;

    // Counter saturation, then clear wins over a concurrent accept.
    lce_v = 4'b0010;
    yumi  = 1'b1;
    for (int c = 0; c < 20; c++) step();
    @(negedge clk);
    chk("sat_count", 128'(counts[1*CW +: CW]), 128'(15));
    clear = 1'b1;
    step();
    clear = 1'b0;
    lce_v = '0;
    yumi  = 1'b0;
    @(negedge clk);
    chk("clear_vs_accept", 128'(counts[1*CW +: CW]), 128'(0));
    step();

    // Watchdog: eight stalled cycles, flag visible from the ninth.
`ifdef BP_ME_CCE_REQ_MUX_WATCHDOG_EN
    exp_stall = 1'b1;
`else
    exp_stall = 1'b0;
`endif
    lce_v = 4'b0001;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("stall_rise", 128'(stall), 128'((c == 9) ? exp_stall : 1'b0));
      step();
    end
    yumi = 1'b1;
    step();
    yumi  = 1'b0;
    lce_v = '0;
    @(negedge clk);
    chk("stall_sticky", 128'(stall), 128'(exp_stall));
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    chk("stall_clear", 128'(stall), 128'(0));
    step();

    // Reset in the middle of a held transfer on channel 3.
    lce_v = 4'b1000;
    step();
    lce_v = 4'hF;
    @(negedge clk);
    chk("pre_reset_data", 128'(cce_req), 128'(dat[3]));
    step();
    #1 yumi = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_v", 128'(cce_v), 128'(0));
    chk("async_yumi", 128'(yumi_o), 128'(0));
    chk("async_data", 128'(cce_req), 128'(0));
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_grant", 128'(yumi_o), 128'(4'b0001));
    step();
    lce_v = '0;
    yumi  = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
